mrv1_retire: RTL and testbench

MRV1_RETIRE -- requirements
Module: mrv1_retire

---
 rtl/mrv1_retire.sv | 137 +++++++++++++
 tb/tb_mrv1_retire.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mrv1_retire.sv
// rtl/mrv1_retire.sv - per-thread in-order retire with round-robin thread pick
// Completions land in per-thread tag slots; the head slot of one thread retires per cycle.
module mrv1_retire #(
  parameter int NUM_THREADS_P   = 8,
  parameter int DATA_WIDTH_P    = 32,
  parameter int ITAG_WIDTH_P    = 3,
  parameter int rf_addr_width_p = 5,
  localparam int tid_width_lp   = $clog2(NUM_THREADS_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_vld_i,
  input  logic [tid_width_lp-1:0]    wb_tid_i,
  input  logic [ITAG_WIDTH_P-1:0]    wb_itag_i,
  input  logic                       wb_rd_vld_i,
  input  logic [rf_addr_width_p-1:0] wb_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    wb_data_i,
  input  logic                       flush_i,
  input  logic [tid_width_lp-1:0]    flush_tid_i,
  output logic                       rf_we_o,
  output logic [tid_width_lp-1:0]    rf_tid_o,
  output logic [rf_addr_width_p-1:0] rf_addr_o,
  output logic [DATA_WIDTH_P-1:0]    rf_data_o,
  output logic                       retire_vld_o,
  output logic [tid_width_lp-1:0]    retire_tid_o,
  output logic [ITAG_WIDTH_P-1:0]    retire_itag_o,
  output logic                       err_o
);

  localparam int slots_lp = 2 ** ITAG_WIDTH_P;

  logic [slots_lp-1:0]        done_q    [NUM_THREADS_P];
  logic [ITAG_WIDTH_P-1:0]    head_q    [NUM_THREADS_P];
  logic                       rd_vld_q  [NUM_THREADS_P][slots_lp];
  logic [rf_addr_width_p-1:0] rd_addr_q [NUM_THREADS_P][slots_lp];
  logic [DATA_WIDTH_P-1:0]    data_q    [NUM_THREADS_P][slots_lp];
  logic [tid_width_lp-1:0]    last_tid_q, last_tid_d;
  logic                       err_q, err_d;

  logic [NUM_THREADS_P-1:0]   elig;
  logic                       sel_vld;
  logic [tid_width_lp-1:0]    sel_tid;
  logic [ITAG_WIDTH_P-1:0]    sel_head;
  logic                       sel_rd_vld;
  logic [rf_addr_width_p-1:0] sel_rd_addr;
  logic [DATA_WIDTH_P-1:0]    sel_data;
  logic                       ret_vld;
  logic                       wb_flushed, wb_slot_retiring, wb_dup, wb_accept;

  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      elig[t] = done_q[t][head_q[t]] && !(flush_i && (flush_tid_i == tid_width_lp'(t)));
    end
  end

  // Round-robin search starting one past the last thread that retired.
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_tid = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_THREADS_P; i++) begin
      idx = (int'(last_tid_q) + i) % NUM_THREADS_P;
      if (!sel_vld && elig[idx]) begin
        sel_vld = 1'b1;
        sel_tid = tid_width_lp'(idx);
      end
    end
  end

  always_comb begin
    sel_head    = head_q[sel_tid];
    sel_rd_vld  = rd_vld_q[sel_tid][sel_head];
    sel_rd_addr = rd_addr_q[sel_tid][sel_head];
    sel_data    = data_q[sel_tid][sel_head];
    ret_vld     = sel_vld && !rst_i;
    last_tid_d  = ret_vld ? sel_tid : last_tid_q;
  end

  // A slot retiring this cycle may be refilled; any other done slot is a duplicate.
  always_comb begin
    wb_flushed       = flush_i && (flush_tid_i == wb_tid_i);
    wb_slot_retiring = sel_vld && (sel_tid == wb_tid_i) && (sel_head == wb_itag_i);
    wb_dup           = done_q[wb_tid_i][wb_itag_i] && !wb_slot_retiring;
    wb_accept        = wb_vld_i && !wb_flushed && !wb_dup;
    err_d            = err_q | (wb_vld_i && !wb_flushed && wb_dup);
  end

  always_comb begin
    retire_vld_o  = ret_vld;
    retire_tid_o  = ret_vld ? sel_tid : '0;
    retire_itag_o = ret_vld ? sel_head : '0;
    rf_tid_o      = ret_vld ? sel_tid : '0;
    rf_we_o       = ret_vld && sel_rd_vld && (sel_rd_addr != '0);
    rf_addr_o     = rf_we_o ? sel_rd_addr : '0;
    rf_data_o     = rf_we_o ? sel_data : '0;
    err_o         = err_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_tid_q <= tid_width_lp'(NUM_THREADS_P - 1);
      err_q      <= 1'b0;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        done_q[t] <= '0;
        head_q[t] <= '0;
        for (int s = 0; s < slots_lp; s++) begin
          rd_vld_q[t][s]  <= 1'b0;
          rd_addr_q[t][s] <= '0;
          data_q[t][s]    <= '0;
        end
      end
    end else begin
      last_tid_q <= last_tid_d;
      err_q      <= err_d;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        if (flush_i && (flush_tid_i == tid_width_lp'(t))) begin
          done_q[t] <= '0;
          head_q[t] <= '0;
        end else begin
          if (sel_vld && (sel_tid == tid_width_lp'(t))) begin
            done_q[t][head_q[t]] <= 1'b0;
            head_q[t]            <= head_q[t] + 1'b1;
          end
          // Later assignment gives a same-slot completion priority over the retire clear.
          if (wb_accept && (wb_tid_i == tid_width_lp'(t))) begin
            done_q[t][wb_itag_i]    <= 1'b1;
            rd_vld_q[t][wb_itag_i]  <= wb_rd_vld_i;
            rd_addr_q[t][wb_itag_i] <= wb_rd_addr_i;
            data_q[t][wb_itag_i]    <= wb_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mrv1_retire.sv
// tb/tb_mrv1_retire.sv - directed vector bench for mrv1_retire
module tb_mrv1_retire;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb_vld_i = 1'b0;
  logic [2:0]  wb_tid_i = '0;
  logic [2:0]  wb_itag_i = '0;
  logic        wb_rd_vld_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        flush_i = 1'b0;
  logic [2:0]  flush_tid_i = '0;
  logic        rf_we_o;
  logic [2:0]  rf_tid_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        retire_vld_o;
  logic [2:0]  retire_tid_o;
  logic [2:0]  retire_itag_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  mrv1_retire dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_vld_i(wb_vld_i), .wb_tid_i(wb_tid_i), .wb_itag_i(wb_itag_i),
    .wb_rd_vld_i(wb_rd_vld_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .flush_tid_i(flush_tid_i),
    .rf_we_o(rf_we_o), .rf_tid_o(rf_tid_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .retire_vld_o(retire_vld_o), .retire_tid_o(retire_tid_o), .retire_itag_o(retire_itag_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wv;
    logic [2:0]  wt;
    logic [2:0]  wi;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [2:0]  ft;
    logic        ev;
    logic [2:0]  et;
    logic [2:0]  ei;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int wv, wt, wi, wr, wa, wd, fl, ft,
                              input int ev, et, ei, ewe, ea, ed, eerr);
    vec_t v;
    v.wv = 1'(wv);  v.wt = 3'(wt);  v.wi = 3'(wi);  v.wr = 1'(wr);
    v.wa = 5'(wa);  v.wd = 32'(wd); v.fl = 1'(fl);  v.ft = 3'(ft);
    v.ev = 1'(ev);  v.et = 3'(et);  v.ei = 3'(ei);  v.ewe = 1'(ewe);
    v.ea = 5'(ea);  v.ed = 32'(ed); v.eerr = 1'(eerr);
    return v;
  endfunction

  function automatic logic [48:0] pack_exp(input logic ev, input logic [2:0] et, input logic [2:0] ei,
                                           input logic ewe, input logic [4:0] ea,
                                           input logic [31:0] ed, input logic eerr);
    return {ev, ev ? et : 3'd0, ev ? ei : 3'd0, ewe, ev ? et : 3'd0, ea, ed, eerr};
  endfunction

  task automatic chk(input string name, input logic [48:0] exp_v);
    logic [48:0] act;
    act = {retire_vld_o, retire_tid_o, retire_itag_o, rf_we_o, rf_tid_o, rf_addr_o, rf_data_o, err_o};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wt, input logic [2:0] wi,
                       input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic [2:0] ft);
    wb_vld_i = wv; wb_tid_i = wt; wb_itag_i = wi; wb_rd_vld_i = wr;
    wb_rd_addr_i = wa; wb_data_i = wd; flush_i = fl; flush_tid_i = ft;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // in-order retire
    vecs.push_back(mk(1,2,0,1,5,32'hDEADBEEF,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,2,0,1,5,32'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // out-of-order completion on thread 1
    vecs.push_back(mk(1,1,1,1,3,32'h11,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,1,4,32'h10,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,1,4,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,1,1,3,32'h11,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // round-robin across threads 0, 3, 7
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,3,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,7,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,3,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    vecs.push_back(mk(1,7,0,0,0,0,0,0, 1,3,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,7,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,3,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,7,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // flush thread 0, then tags 0..7 and 0 again; tag 0 first writes x0
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    for (int k = 0; k < 8; k++) begin
      if (k == 0) vecs.push_back(mk(1,0,0,1,0,0,0,0, 0,0,0,0,0,0,0));
      else vecs.push_back(mk(1,0,k,1,k,k*256,0,0, 1,0,k-1,(k-1) != 0,
                             (k-1) != 0 ? k-1 : 0, (k-1) != 0 ? (k-1)*256 : 0, 0));
    end
    vecs.push_back(mk(1,0,0,1,9,32'h99,0,0, 1,0,7,1,7,32'h700,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,1,9,32'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    // flush collision on thread 4
    vecs.push_back(mk(1,4,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,4,1,0,0,0,0,0, 1,4,0,0,0,0,0));
    vecs.push_back(mk(1,4,2,1,1,32'h55,1,4, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,4,0,1,7,32'h44,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,4,0,1,7,32'h44,0));
    // same-slot refill during retire, then duplicate completion raises sticky error
    vecs.push_back(mk(1,5,0,1,6,32'hA,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,5,0,1,6,32'hB,0,0, 1,5,0,1,6,32'hA,0));
    vecs.push_back(mk(1,5,0,1,6,32'hC,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));

    #2 rst_i = 1'b1;
    #1 chk("reset_async", '0);
    @(negedge clk_i);
    chk("reset_held", '0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].wt, vecs[i].wi, vecs[i].wr, vecs[i].wa, vecs[i].wd,
            vecs[i].fl, vecs[i].ft);
      #1;
      chk($sformatf("vec%0d", i), pack_exp(vecs[i].ev, vecs[i].et, vecs[i].ei, vecs[i].ewe,
                                           vecs[i].ea, vecs[i].ed, vecs[i].eerr));
      @(negedge clk_i);
    end

    // mid-run reset with three done entries on thread 6
    drive(1, 6, 1, 1, 2, 32'h61, 0, 0);
    @(negedge clk_i);
    drive(1, 6, 2, 1, 2, 32'h62, 0, 0);
    @(negedge clk_i);
    drive(1, 6, 0, 1, 2, 32'h60, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pre_reset_retire", pack_exp(1, 6, 0, 1, 2, 32'h60, 1));
    #2 rst_i = 1'b1;
    #1 chk("midrun_reset_outputs", '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("post_reset_idle%0d", c), '0);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
